// File: rtl/jstk_spi_xfer.sv
// SPI mode-0 five-byte full-duplex transaction engine for the PmodJSTK joystick.
// A rising edge on sndRec runs one exchange; DOUT is updated atomically on completion.
module jstk_spi_xfer #(
    parameter int SCLK_HALF = 45,
    parameter int SS_SETUP  = 180,
    parameter int BYTE_GAP  = 120
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        sndRec,
    input  logic [39:0] DIN,
    input  logic        MISO,
    output logic        SS,
    output logic        SCLK,
    output logic        MOSI,
    output logic [39:0] DOUT,
    output logic        busy,
    output logic        done
);

    localparam int CNT_MAX_A = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int CNT_MAX   = (CNT_MAX_A > SCLK_HALF) ? CNT_MAX_A : SCLK_HALF;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] SETUP_END = CW'(SS_SETUP - 1);
    localparam logic [CW-1:0] HALF_END  = CW'(SCLK_HALF - 1);
    localparam logic [CW-1:0] GAP_END   = CW'(BYTE_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SSWAIT = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    byte_q, byte_d;
    logic [39:0]   tx_q, tx_d;
    logic [39:0]   rx_q, rx_d;
    logic [39:0]   dout_q, dout_d;
    logic          ss_q, ss_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          sndrec_q;
    logic          start_s;

    // State, counters, shift registers and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            bit_q    <= 3'd0;
            byte_q   <= 3'd0;
            tx_q     <= 40'd0;
            rx_q     <= 40'd0;
            dout_q   <= 40'd0;
            ss_q     <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sndrec_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            dout_q   <= dout_d;
            ss_q     <= ss_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sndrec_q <= sndRec;
        end
    end

    // busy_q gates acceptance so the done cycle itself cannot start a new transfer.
    assign start_s = sndRec & ~sndrec_q & (state_q == ST_IDLE) & ~busy_q;

    // Next-state and output logic for the transaction sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        ss_d    = ss_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ss_d   = 1'b1;
                sclk_d = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                if (start_s) begin
                    state_d = ST_SSWAIT;
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    tx_d    = DIN;
                    rx_d    = 40'd0;
                    cnt_d   = CNT_ZERO;
                    bit_d   = 3'd0;
                    byte_d  = 3'd0;
                end else begin
                    cnt_d = CNT_ZERO;
                end
            end

            ST_SSWAIT: begin
                if (cnt_q == SETUP_END) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_ZERO;
                    mosi_d  = tx_q[39];
                    tx_d    = {tx_q[38:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_SHIFT: begin
                if (cnt_q == HALF_END) begin
                    cnt_d = CNT_ZERO;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[38:0], MISO};
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            bit_d = 3'd0;
                            if (byte_q == 3'd4) begin
                                state_d = ST_FINISH;
                            end else begin
                                state_d = ST_GAP;
                                byte_d  = byte_q + 3'd1;
                            end
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            mosi_d = tx_q[39];
                            tx_d   = {tx_q[38:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    state_d = ST_SHIFT;
                    cnt_d   = CNT_ZERO;
                    mosi_d  = tx_q[39];
                    tx_d    = {tx_q[38:0], 1'b0};
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_FINISH: begin
                if (cnt_q == HALF_END) begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                    ss_d    = 1'b1;
                    mosi_d  = 1'b0;
                    dout_d  = rx_q;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                ss_d    = 1'b1;
                sclk_d  = 1'b0;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign SS   = ss_q;
    assign SCLK = sclk_q;
    assign MOSI = mosi_q;
    assign DOUT = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
